// File: rtl/ascon_spi_pkg.sv
// Constants and types shared by the tx (piso) and rx (sipo) ends of the serial link.
package ascon_spi_pkg;

    localparam int SPI_WORD_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/piso_spi_tx.sv
// Parallel-in/serial-out transmitter: MSB-first on sdo, cs framing each word, with a
// one-word holding buffer so back-to-back words stream without a cs gap.
module piso_spi_tx
    import ascon_spi_pkg::*;
#(
    parameter int WIDTH = SPI_WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pdi,
    input  logic             pdi_valid,
    output logic             pdi_ready,
    output logic             sdo,
    output logic             cs,
    output logic             word_done
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_valid_q, buf_valid_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             cs_q, cs_d;
    logic             done_q, done_d;
    logic             xfer;
    logic             last_bit;

    assign pdi_ready = !buf_valid_q;
    assign xfer      = pdi_valid && pdi_ready;
    assign last_bit  = (bit_cnt_q == LAST);

    assign sdo       = shreg_q[WIDTH-1];
    assign cs        = cs_q;
    assign word_done = done_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        bit_cnt_d   = bit_cnt_q;
        cs_d        = cs_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // First word goes straight to the shifter, bypassing the buffer.
                if (xfer) begin
                    shreg_d   = pdi;
                    bit_cnt_d = '0;
                    cs_d      = 1'b1;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (last_bit) begin
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                    if (buf_valid_q) begin
                        shreg_d     = buf_q;
                        buf_valid_d = 1'b0;
                    end else if (xfer) begin
                        // Word arriving on the last-bit edge reloads directly: no cs gap.
                        shreg_d = pdi;
                    end else begin
                        shreg_d = '0;
                        cs_d    = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (xfer) begin
                        buf_d       = pdi;
                        buf_valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cs_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            bit_cnt_q   <= '0;
            cs_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            bit_cnt_q   <= bit_cnt_d;
            cs_q        <= cs_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_piso_spi_tx.sv
// Directed bench for piso_spi_tx: a per-cycle vector table plus hand-written multi-cycle
// sequences, with a behavioural sipo receiver looped onto sdo/cs.
module tb_piso_spi_tx;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] pdi;
    logic         pdi_valid;
    logic         pdi_ready;
    logic         sdo;
    logic         cs;
    logic         word_done;

    piso_spi_tx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pdi       (pdi),
        .pdi_valid (pdi_valid),
        .pdi_ready (pdi_ready),
        .sdo       (sdo),
        .cs        (cs),
        .word_done (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // receiver model and link counters
    int           cyc     = 0;
    int           cs_cyc  = 0;
    int           cs_runs = 0;
    int           wd_cnt  = 0;
    int           bitn    = 0;
    logic         cs_prev = 1'b0;
    logic [W-1:0] sr      = '0;
    logic [W-1:0] rxq[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            bitn    = 0;
            cs_prev = 1'b0;
        end else begin
            if (cs === 1'b1) begin
                cs_cyc = cs_cyc + 1;
                if (!cs_prev) cs_runs = cs_runs + 1;
                sr = {sr[W-2:0], sdo};
                bitn = bitn + 1;
                if (bitn == W) begin
                    rxq.push_back(sr);
                    bitn = 0;
                end
            end
            if (word_done === 1'b1) wd_cnt = wd_cnt + 1;
            cs_prev = (cs === 1'b1);
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        cs_cyc  = 0;
        cs_runs = 0;
        wd_cnt  = 0;
        rxq.delete();
    endtask

    // Present a word; returns #1 after the accepting edge with pdi_valid dropped.
    task automatic send(input logic [W-1:0] w, output int acc_cyc);
        logic r;
        bit   ok;
        ok        = 1'b0;
        acc_cyc   = -1;
        pdi       = w;
        pdi_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            r = pdi_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok      = 1'b1;
                acc_cyc = cyc;
            end
        end
        pdi_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_wd(input int n);
        int i;
        i = 0;
        while (wd_cnt < n && i < 500) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (wd_cnt < n) check("word_done_timeout", W'(wd_cnt), W'(n));
        repeat (4) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         rst_n;
        logic         vld;
        logic [W-1:0] pdi;
        logic         e_cs;
        logic         e_sdo;
        logic         e_rdy;
        logic         e_wd;
    } vec_t;

    vec_t vt[6];

    initial begin
        int a1, a2, a3;

        rst_n     = 1'b0;
        pdi_valid = 1'b1;
        pdi       = 32'hFFFF_FFFF;

        // reset with valid asserted, accept a word, then reset it mid-flight
        vt[0] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[1] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b1, 1'b1, 32'h8000_0001, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 6; i++) begin
            rst_n     = vt[i].rst_n;
            pdi_valid = vt[i].vld;
            pdi       = vt[i].pdi;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_cs", i),   W'(cs),        W'(vt[i].e_cs));
            check($sformatf("vec%0d_sdo", i),  W'(sdo),       W'(vt[i].e_sdo));
            check($sformatf("vec%0d_rdy", i),  W'(pdi_ready), W'(vt[i].e_rdy));
            check($sformatf("vec%0d_wd", i),   W'(word_done), W'(vt[i].e_wd));
        end
        rst_n     = 1'b1;
        pdi_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single word
        clr_mon();
        send(32'hA5A5_0F0F, a1);
        check("single_first_sdo", W'(sdo), 32'd1);
        check("single_first_cs", W'(cs), 32'd1);
        wait_wd(1);
        check("single_cs_cycles", W'(cs_cyc), 32'd32);
        check("single_cs_runs", W'(cs_runs), 32'd1);
        check("single_wd_count", W'(wd_cnt), 32'd1);
        check("single_rx_count", W'(rxq.size()), 32'd1);
        if (rxq.size() >= 1) check("single_rx_word", rxq[0], 32'hA5A5_0F0F);

        // back-to-back, second offered while first shifts
        clr_mon();
        send(32'hDEAD_BEEF, a1);
        send(32'h0123_4567, a2);
        check("b2b_accept_gap", W'(a2 - a1), 32'd1);
        wait_wd(2);
        check("b2b_cs_cycles", W'(cs_cyc), 32'd64);
        check("b2b_cs_runs", W'(cs_runs), 32'd1);
        check("b2b_rx_count", W'(rxq.size()), 32'd2);
        if (rxq.size() >= 2) begin
            check("b2b_rx0", rxq[0], 32'hDEAD_BEEF);
            check("b2b_rx1", rxq[1], 32'h0123_4567);
        end

        // backpressure: third word waits for the first word's last-bit edge
        clr_mon();
        send(32'h1111_2222, a1);
        send(32'h3333_4444, a2);
        pdi       = 32'h5555_6666;
        pdi_valid = 1'b1;
        check("bp_ready_low", W'(pdi_ready), 32'd0);
        send(32'h5555_6666, a3);
        check("bp_accept3_delay", W'(a3 - a1), 32'd33);
        wait_wd(3);
        check("bp_cs_cycles", W'(cs_cyc), 32'd96);
        check("bp_cs_runs", W'(cs_runs), 32'd1);
        check("bp_rx_count", W'(rxq.size()), 32'd3);
        if (rxq.size() >= 3) begin
            check("bp_rx0", rxq[0], 32'h1111_2222);
            check("bp_rx1", rxq[1], 32'h3333_4444);
            check("bp_rx2", rxq[2], 32'h5555_6666);
        end

        // reset mid-word with buffer full
        clr_mon();
        send(32'hFFFF_FFFF, a1);
        send(32'hFFFF_FFFF, a2);
        check("rst_buf_full", W'(pdi_ready), 32'd0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_cs", W'(cs), 32'd0);
        check("rst_sdo", W'(sdo), 32'd0);
        check("rst_ready", W'(pdi_ready), 32'd1);
        check("rst_wd", W'(word_done), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("rst_no_wd", W'(wd_cnt), 32'd0);
        check("rst_cs_stays_low", W'(cs), 32'd0);
        clr_mon();
        send(32'h0000_0001, a1);
        wait_wd(1);
        check("rst_next_cs_cycles", W'(cs_cyc), 32'd32);
        check("rst_next_rx_count", W'(rxq.size()), 32'd1);
        if (rxq.size() >= 1) check("rst_next_rx", rxq[0], 32'h0000_0001);

        // word offered exactly on the last-bit edge with the buffer empty
        clr_mon();
        send(32'h1234_5678, a1);
        repeat (31) @(posedge clk);
        #1;
        pdi       = 32'h8765_4321;
        pdi_valid = 1'b1;
        @(posedge clk);
        #1;
        pdi_valid = 1'b0;
        check("edge_cs", W'(cs), 32'd1);
        check("edge_sdo", W'(sdo), 32'd1);
        check("edge_wd", W'(word_done), 32'd1);
        wait_wd(2);
        check("edge_cs_cycles", W'(cs_cyc), 32'd64);
        check("edge_cs_runs", W'(cs_runs), 32'd1);
        check("edge_rx_count", W'(rxq.size()), 32'd2);
        if (rxq.size() >= 2) begin
            check("edge_rx0", rxq[0], 32'h1234_5678);
            check("edge_rx1", rxq[1], 32'h8765_4321);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
